hs_rx_fifo: RTL
===============

# hs_rx_fifo

Receiving end of the 32-bit valid/ready point-to-point handshake used between `master` and `slave`. It accepts words from a handshake initiator, buffers them in a small FIFO and presents them show-ahead to a local consumer through a pop interface. `ready` is driven from registered state only, so there is never a combinational path from `valid` to `ready`. It is instantiated as the slave-side landing buffer wherever a consumer cannot take a word every cycle.

## Interface
- `DATA_W`, 32, payload width
- `DEPTH`, 4, FIFO entries; power of two, at least 2
- `clk`  input  1  clock; all logic on the rising edge
- `reset`  input  1  asynchronous, active-low reset (0 = in reset)
- `valid`  input  1  initiator has a word on `data`
- `data`  input  DATA_W  payload
- `ready`  output  1  buffer can accept a word this cycle
- `rd_en`  input  1  consumer pops the head word
- `rd_data`  output  DATA_W  head word, show-ahead
- `rd_valid`  output  1  FIFO non-empty; `rd_data` is meaningful
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `proto_err`  output  1  sticky handshake-violation flag (see Configuration)

## Operation
- Write: `valid && ready` at a rising edge stores `data` at `wr_ptr`, then `wr_ptr` increments.
- Read: `rd_en && rd_valid` at a rising edge advances `rd_ptr`. `rd_en` while empty is ignored and has no effect on state.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- `count` increments on write-only, decrements on read-only and holds on simultaneous read and write.
- `ready = reset && (count != DEPTH)`. When full, `ready` is 0 even if `rd_en` is high in the same cycle; there is no write-through on full.
- `rd_valid = (count != 0)`. `rd_data = mem[rd_ptr]` when `rd_valid`, otherwise 0.
- Simultaneous read and write while empty: the read is ignored, the write is accepted, and `count` becomes 1.
- Memory contents are not reset. Reset clears only the pointers, `count` and `proto_err`.
- Reset asserted mid-operation: all buffered words are discarded immediately, and outputs take their reset values asynchronously.

## Timing
- Reset values: `ready`=0 (while `reset`=0), `rd_valid`=0, `rd_data`=0, `count`=0, `proto_err`=0.
- `ready` rises combinationally with `reset` deassertion, so the first write is possible on the first edge after release.
- Write-to-read latency is 1 cycle: a word accepted at edge N appears on `rd_data` with `rd_valid`=1 after edge N.
- Pop-to-ready latency is 1 cycle: a pop at edge N on a full FIFO raises `ready` after edge N.
- Sustained throughput is 1 word per cycle when the consumer pops every cycle.

## Configuration
- Macro: `HS_RX_PROTO_CHK_EN`.
- Defined: the block registers `stall = valid && !ready` and the value of `data` each cycle. If `stall` was 1 in the previous cycle and now `valid`=0 or `data` differs from the registered value, `proto_err` sets to 1 on that edge. It stays set until reset.
- Not defined: the checker logic is absent and `proto_err` is tied to 0. Port list unchanged.

## Test plan
- Reset release: hold `reset`=0 for 100 ns, then release -> `ready`=1, `rd_valid`=0 and `count`=0 immediately after release; `rd_data`=0.
- Single word: one-cycle `valid` with `data`=32'h20220503, `rd_en`=0 -> `count`=1 and `rd_data`=32'h20220503 one cycle later; pop -> `count`=0, `rd_data`=0.
- Fill and backpressure: 5 consecutive words 32'h10000006..32'h1000000A, no pops -> `ready`=0 after the 4th; the 5th word is held; one pop -> `ready`=1 next cycle, 5th word accepted, pop order 06,07,08,09,0A.
- Wrap and streaming: 10 words with `rd_en`=1 continuously -> `count` never exceeds 1 after the first, all words out in order, pointers wrap twice.
- Edge cases: `rd_en`=1 while empty -> no state change; `reset`=0 pulse with 3 words buffered -> `count`=0, `rd_valid`=0 immediately.
- Checker (macro defined): fill the FIFO, then drop `valid` while `ready`=0 -> `proto_err`=1 after that edge and stays 1; macro undefined -> `proto_err`=0 throughout.

Source files
------------

// File: rtl/hs_rx_fifo_if.sv
// hs_rx_fifo_if: 32-bit valid/ready point-to-point handshake bundle.
//   valid  - initiator has a word on data (driven by master)
//   data   - payload, DATA_W bits (driven by master)
//   ready  - receiver can accept a word this cycle (driven by slave)
// Modports: master (initiator side), slave (receiver side).
interface hs_rx_fifo_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/hs_rx_fifo.sv
// hs_rx_fifo: slave-side landing buffer for the valid/ready handshake.
// Accepts words from the initiator into a DEPTH-entry FIFO and presents the
// head word show-ahead to a local consumer. ready depends only on registered
// occupancy and the reset input, never on valid.
//
// Ports:
//   clk       - clock, all logic on the rising edge
//   reset     - asynchronous active-low reset (0 = in reset)
//   hs        - handshake bundle (slave modport): valid, data in; ready out
//   rd_en     - consumer pops the head word (ignored while empty)
//   rd_data   - head word when rd_valid, otherwise 0
//   rd_valid  - FIFO non-empty
//   count     - occupancy, 0..DEPTH
//   proto_err - sticky handshake-violation flag
//
// Optional feature: define HS_RX_PROTO_CHK_EN to enable the handshake
// protocol checker (valid dropped or data changed while stalled). Without the
// macro, proto_err is tied to 0.
module hs_rx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  hs_rx_fifo_if.slave              hs,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt_s;
  logic              ready_s;
  logic              rd_valid_s;
  logic              wr_fire_s;
  logic              rd_fire_s;

  // Gating ready with reset makes it drop asynchronously on reset assertion
  // and rise as soon as reset is released.
  assign ready_s    = reset && (count_r != CW'(DEPTH));
  assign rd_valid_s = (count_r != {CW{1'b0}});
  assign wr_fire_s  = hs.valid && ready_s;
  assign rd_fire_s  = rd_en && rd_valid_s;

  assign hs.ready = ready_s;
  assign rd_valid = rd_valid_s;
  assign rd_data  = rd_valid_s ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign count    = count_r;

  // Occupancy update: +1 on write only, -1 on read only, hold otherwise.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_fire_s, rd_fire_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r] <= hs.data;
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

`ifdef HS_RX_PROTO_CHK_EN
  logic              stall_r;
  logic [DATA_W-1:0] data_r;
  logic              proto_err_r;

  // Protocol checker: once stalled, the initiator must hold valid and data
  // stable until the word is taken; any violation sets a sticky flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_r     <= 1'b0;
      data_r      <= {DATA_W{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      stall_r <= hs.valid && !ready_s;
      data_r  <= hs.data;
      if (stall_r && (!hs.valid || (hs.data != data_r))) begin
        proto_err_r <= 1'b1;
      end else begin
        proto_err_r <= proto_err_r;
      end
    end
  end

  assign proto_err = proto_err_r;
`else
  assign proto_err = 1'b0;
`endif

endmodule
